serial_adder_seq: RTL and testbench
===================================

Name: serial_adder_seq

Overview:
Bit-serial N-bit adder sequencer. It drives the 1-bit full-adder cell one bit per cycle, LSB first, and holds the running carry in a flop. It accepts operands over a valid/ready handshake and returns the N-bit sum plus carry-out over a second valid/ready handshake. It sits inside the tt_um_islam_ihfaz_full_adder user project, between the ui_in/uio_in operand pins and the full-adder cell.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..16.
CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when low, all state holds
start_valid  input  1  operands presented
start_ready  output  1  block can accept operands
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
cin  input  1  carry-in, sampled with the operands
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
sum_out  output  WIDTH  sum, valid while res_valid is high
cout  output  1  final carry-out, valid while res_valid is high
busy  output  1  high in RUN

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; a_sh, b_sh, sum_sh = 0; carry=0; cnt=0.
- Outputs during reset: start_ready=1, res_valid=0, sum_out=0, cout=0, busy=0.
- All registered updates are gated by ena. With ena=0, state, counters and shift registers hold, and no handshake completes.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready&ena: a_sh<=a_in, b_sh<=b_in, carry<=cin, cnt<=0, sum_sh<=0, go to RUN.
- RUN (WIDTH enabled cycles):
  - Each enabled cycle, the full-adder cell takes a_sh[0], b_sh[0] and carry.
  - a_sh and b_sh shift right by 1 (zero fill).
  - sum_sh shifts right, with the cell's sum bit entering at the MSB.
  - carry<=cell cout; cnt<=cnt+1.
  - When cnt==WIDTH-1 on an enabled cycle, go to DONE.
  - start_ready=0, busy=1; start_valid is ignored.
- DONE:
  - res_valid=1; sum_out=sum_sh; cout=carry.
  - sum_out and cout are stable until accepted.
  - On res_valid&res_ready&ena: go to IDLE.
  - After acceptance, sum_out and cout keep their last value; they are don't-care outside res_valid.
- Latency: the accept edge is cycle 0. res_valid rises after the edge of cycle WIDTH, i.e. it is visible in cycle WIDTH+1 when ena stays high. Each ena-low cycle adds one cycle.
- Throughput: one addition per WIDTH+2 cycles minimum. There is no accept in the same cycle as result drain; start_ready only rises in IDLE.
- Backpressure: res_ready low holds DONE indefinitely with outputs frozen.
- Arithmetic: {cout,sum_out} == a_in + b_in + cin, exact. There is no overflow flag beyond cout.
- Reset mid-RUN or mid-DONE: immediate abort to IDLE. The partial result is discarded and res_valid is never asserted for it.
- start_valid held high across several cycles: only one capture, on the IDLE accept edge. A new capture requires a return to IDLE.
- X on a_in/b_in outside an accept cycle must not propagate (they are not sampled).

Decomposition:
- Shared package serial_adder_pkg:
  - state enum {S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2}.
  - localparam DEFAULT_WIDTH=8.
- Sub-module fa_cell:
  - Purely combinational 1-bit full adder: inputs a, b, ci; outputs s, co.
  - Instantiated once.
- Top-level pin mapping (ui_in/uio_in to operands, uo_out to sum) is done in tt_um_islam_ihfaz_full_adder, not here.

Test Plan:
- a=8'h12, b=8'h34, cin=0, res_ready=1 -> res_valid in cycle 9, sum_out=8'h46, cout=0; start_ready low cycles 1-9.
- a=8'hFF, b=8'h01, cin=0 -> sum_out=8'h00, cout=1.
- a=8'h5A, b=8'hA5, cin=1 -> sum_out=8'h00, cout=1; then a=8'h00, b=8'h00, cin=0 -> 8'h00, cout=0.
- res_ready held low 5 cycles after res_valid -> sum_out/cout stable. start_valid=1 during those cycles is not accepted (start_ready=0). The second transaction completes only after drain.
- ena deasserted for 3 cycles mid-RUN (a=8'hC3, b=8'h3C, cin=1) -> result sum_out=8'h00, cout=1 arrives 3 cycles late.
- rst_n pulsed low at cycle 4 of RUN -> outputs immediately at reset values, no spurious res_valid. The next add (8'h80+8'h80, cin=0) gives sum_out=8'h00, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_adder_pkg;

    // Sequencer states: wait for operands, shift bits through the cell, hold result.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_seq_if.sv
// Operand/result handshake bundle between the pin wrapper (master) and the sequencer (slave).
interface serial_adder_seq_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             busy;

    modport master (
        output start_valid, a_in, b_in, cin, res_ready,
        input  start_ready, res_valid, sum_out, cout, busy
    );

    modport slave (
        input  start_valid, a_in, b_in, cin, res_ready,
        output start_ready, res_valid, sum_out, cout, busy
    );
endinterface

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer: feeds one operand bit pair per enabled cycle, LSB first,
// through a single full-adder cell and keeps the running carry in a flop.
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    serial_adder_seq_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_fa_s;
    logic               w_fa_co;

    assign w_accept = (r_state == S_IDLE) && bus.start_valid;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    fa_cell u_fa_cell (
        .a  (r_a_sh[0]),
        .b  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    // Next-state decode; ena gating is applied at the state register.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start_valid) w_state_next = S_RUN;
            S_RUN:   if (w_last)          w_state_next = S_DONE;
            S_DONE:  if (bus.res_ready)   w_state_next = S_IDLE;
            default:                      w_state_next = S_IDLE;
        endcase
    end

    // State register; holds while ena is low so no handshake can complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    // Operand capture on accept, then one shift per enabled RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (ena) begin
            if (w_accept) begin
                r_a_sh   <= bus.a_in;
                r_b_sh   <= bus.b_in;
                r_sum_sh <= '0;
                r_carry  <= bus.cin;
                r_cnt    <= '0;
            end else if (r_state == S_RUN) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                r_sum_sh <= {w_fa_s, r_sum_sh[WIDTH-1:1]};
                r_carry  <= w_fa_co;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs come only from state and registers, never straight from inputs.
    assign bus.start_ready = (r_state == S_IDLE);
    assign bus.busy        = (r_state == S_RUN);
    assign bus.res_valid   = (r_state == S_DONE);
    assign bus.sum_out     = r_sum_sh;
    assign bus.cout        = r_carry;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: directed and random additions against
// a plain-arithmetic reference, plus backpressure, ena stall and mid-run reset.
module tb_serial_adder_seq;
    localparam int unsigned W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_seq_if #(.WIDTH(W)) bus ();

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    // Reference: exact (W+1)-bit sum.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
        return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for res_valid (not drained). lat counts edges after the
    // accept edge; ena is dropped for stall_len edges starting at edge index stall_at.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input int stall_at, input int stall_len,
                           output logic [W-1:0] s, output logic co, output int lat,
                           output bit sr_low, output bit timed_out);
        bus.a_in        = a;
        bus.b_in        = b;
        bus.cin         = ci;
        bus.start_valid = 1'b1;
        bus.res_ready   = 1'b0;
        tick();
        bus.start_valid = 1'b0;
        // Operands are not sampled after accept; scramble them.
        bus.a_in = W'($urandom);
        bus.b_in = W'($urandom);
        bus.cin  = 1'($urandom);
        lat = 0;
        sr_low = 1'b1;
        timed_out = 1'b0;
        while (!bus.res_valid) begin
            if (bus.start_ready) sr_low = 1'b0;
            ena = !(lat >= stall_at && lat < stall_at + stall_len);
            tick();
            lat++;
            if (lat > 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        ena = 1'b1;
        if (bus.start_ready) sr_low = 1'b0;
        s  = bus.sum_out;
        co = bus.cout;
    endtask

    task automatic drain();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.cin  = 1'b0;
        #1;
        n_checks++;
        if (bus.start_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_start_ready got %b want 1", bus.start_ready);
        end
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid);
        end
        n_checks++;
        if (bus.sum_out !== '0 || bus.cout !== 1'b0) begin
            n_errors++; $display("FAIL reset_result got %h/%b want 00/0", bus.sum_out, bus.cout);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic         tc [4];
        logic [W-1:0] s;
        logic         co;
        int           lat;
        bit           srl;
        bit           to;
        ta = '{8'h12, 8'hFF, 8'h5A, 8'h00};
        tb = '{8'h34, 8'h01, 8'hA5, 8'h00};
        tc = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_add(ta[i], tb[i], tc[i], -1, 0, s, co, lat, srl, to);
            n_checks++;
            if (to || {co, s} !== model(ta[i], tb[i], tc[i])) begin
                n_errors++;
                $display("FAIL directed_%0d result got %b_%h want %h (timeout=%0b)",
                         i, co, s, model(ta[i], tb[i], tc[i]), to);
            end
            n_checks++;
            if (lat != W) begin
                n_errors++; $display("FAIL directed_%0d latency got %0d want %0d", i, lat, W);
            end
            n_checks++;
            if (!srl) begin
                n_errors++; $display("FAIL directed_%0d start_ready high while busy/done", i);
            end
            drain();
            n_checks++;
            if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL directed_%0d after_drain res_valid=%b start_ready=%b want 0/1",
                         i, bus.res_valid, bus.start_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, s;
        logic         ci, co;
        int           lat;
        bit           srl, to, held_ok;
        a = W'($urandom);
        b = W'($urandom);
        ci = 1'($urandom);
        run_add(a, b, ci, -1, 0, s, co, lat, srl, to);
        n_checks++;
        if (to || {co, s} !== model(a, b, ci)) begin
            n_errors++; $display("FAIL bp_result got %b_%h want %h", co, s, model(a, b, ci));
        end
        // Hold off the result and keep offering new operands.
        held_ok = 1'b1;
        bus.start_valid = 1'b1;
        bus.a_in = W'($urandom);
        bus.b_in = W'($urandom);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.res_valid !== 1'b1 || bus.start_ready !== 1'b0 ||
                {bus.cout, bus.sum_out} !== model(a, b, ci)) held_ok = 1'b0;
        end
        n_checks++;
        if (!held_ok) begin
            n_errors++;
            $display("FAIL bp_hold got valid=%b ready=%b %b_%h want 1/0 %h",
                     bus.res_valid, bus.start_ready, bus.cout, bus.sum_out, model(a, b, ci));
        end
        bus.start_valid = 1'b0;
        drain();
        n_checks++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_drain start_ready=%b busy=%b want 1/0", bus.start_ready, bus.busy);
        end
        a = W'($urandom);
        b = W'($urandom);
        run_add(a, b, 1'b0, -1, 0, s, co, lat, srl, to);
        n_checks++;
        if (to || {co, s} !== model(a, b, 1'b0) || lat != W) begin
            n_errors++;
            $display("FAIL bp_second got %b_%h lat %0d want %h lat %0d",
                     co, s, lat, model(a, b, 1'b0), W);
        end
        drain();
    endtask

    task automatic test_ena_stall();
        logic [W-1:0] s;
        logic         co;
        int           lat;
        bit           srl, to;
        run_add(8'hC3, 8'h3C, 1'b1, 3, 3, s, co, lat, srl, to);
        n_checks++;
        if (to || {co, s} !== model(8'hC3, 8'h3C, 1'b1)) begin
            n_errors++; $display("FAIL stall_result got %b_%h want 1_00", co, s);
        end
        n_checks++;
        if (lat != W + 3) begin
            n_errors++; $display("FAIL stall_latency got %0d want %0d", lat, W + 3);
        end
        // With ena low, a ready consumer still must not drain the result.
        ena = 1'b0;
        drain();
        n_checks++;
        if (bus.res_valid !== 1'b1) begin
            n_errors++; $display("FAIL stall_no_drain res_valid got %b want 1", bus.res_valid);
        end
        ena = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s;
        logic         co;
        int           lat;
        bit           srl, to, spurious;
        bus.a_in = 8'hFF;
        bus.b_in = 8'hFF;
        bus.cin  = 1'b1;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.sum_out !== '0 || bus.cout !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_outputs ready=%b busy=%b valid=%b %b_%h want 1/0/0 0_00",
                     bus.start_ready, bus.busy, bus.res_valid, bus.cout, bus.sum_out);
        end
        tick();
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (bus.res_valid !== 1'b0) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) begin
            n_errors++; $display("FAIL midrst_spurious res_valid got 1 want 0");
        end
        run_add(8'h80, 8'h80, 1'b0, -1, 0, s, co, lat, srl, to);
        n_checks++;
        if (to || {co, s} !== model(8'h80, 8'h80, 1'b0)) begin
            n_errors++; $display("FAIL midrst_next got %b_%h want 1_00", co, s);
        end
        drain();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s;
        logic         ci, co;
        int           lat, sa, sl;
        bit           srl, to;
        for (int i = 0; i < 24; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom);
            sa = int'($urandom_range(0, W - 1));
            sl = int'($urandom_range(0, 3));
            run_add(a, b, ci, sa, sl, s, co, lat, srl, to);
            n_checks++;
            if (to || {co, s} !== model(a, b, ci) || lat != W + sl) begin
                n_errors++;
                $display("FAIL random_%0d %h+%h+%b got %b_%h lat %0d want %h lat %0d",
                         i, a, b, ci, co, s, lat, model(a, b, ci), W + sl);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_ena_stall();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
